// File: rtl/uart_vector_parser_if.sv
// Byte-stream input and record-stream output of the UART vector parser.
// The source/consumer side (master) drives the byte strobe and ready; the parser (slave) drives the rest.
interface uart_vector_parser_if;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Point_Valid;
  logic        i_Point_Ready;
  logic [31:0] o_Point_Data;
  logic        o_Point_Eof;
  logic        o_Overflow;
  logic        o_Sync_Err;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Point_Ready,
    input  o_Point_Valid, o_Point_Data, o_Point_Eof, o_Overflow, o_Sync_Err
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Point_Ready,
    output o_Point_Valid, o_Point_Data, o_Point_Eof, o_Overflow, o_Sync_Err
  );
endinterface

// File: rtl/uart_vector_parser.sv
// Frames UART bytes into 32-bit vector records after a zero-byte preamble and
// queues them in a first-word-fall-through FIFO with valid/ready output.
//
// state     | meaning
// ST_HUNT   | counting consecutive 0x00 bytes, everything else discarded
// ST_SYNCED | preamble seen, waiting for the first non-zero record byte
// ST_RECORD | assembling 4-byte records MSB-first
module uart_vector_parser #(
  parameter int SYNC_LEN     = 4,
  parameter int TIMEOUT_CLKS = 4096,
  parameter int DEPTH        = 16
) (
  input logic                 i_Clock,
  input logic                 i_Rst_n,
  uart_vector_parser_if.slave bus
);

  localparam int          ZCNT_W   = $clog2(SYNC_LEN + 1);
  localparam int          TMR_W    = ($clog2(TIMEOUT_CLKS) > 0) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int          PTR_W    = $clog2(DEPTH);
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [31:0] EOF_WORD = 32'h0101_0101;
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [ZCNT_W-1:0] ZCNT_LAST = ZCNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNCED = 2'd1,
    ST_RECORD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ZCNT_W-1:0] zcnt_q, zcnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       partial_q, partial_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              sync_err_q, sync_err_d;

  logic              dv;
  logic [7:0]        rx_byte;
  logic [31:0]       rec_word;
  logic              push, push_eof, timed_out;

  assign dv       = bus.i_Rx_DV;
  assign rx_byte  = bus.i_Rx_Byte;
  assign rec_word = {partial_q, rx_byte};

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q    <= ST_HUNT;
      zcnt_q     <= '0;
      idx_q      <= '0;
      partial_q  <= '0;
      timer_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      zcnt_q     <= zcnt_d;
      idx_q      <= idx_d;
      partial_q  <= partial_d;
      timer_q    <= timer_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    zcnt_d     = zcnt_q;
    idx_d      = idx_q;
    partial_d  = partial_q;
    timer_d    = timer_q;
    push       = 1'b0;
    push_eof   = 1'b0;
    sync_err_d = 1'b0;

    // Inter-byte timer only runs once synced; any byte reloads it.
    timed_out = (state_q != ST_HUNT) && !dv && (timer_q == '0);
    if (state_q != ST_HUNT && !dv && timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end

    case (state_q)
      ST_HUNT: begin
        if (dv) begin
          if (rx_byte == 8'h00) begin
            if (zcnt_q == ZCNT_LAST) begin
              state_d = ST_SYNCED;
              zcnt_d  = '0;
              timer_d = TMR_LOAD;
            end else begin
              zcnt_d = zcnt_q + 1'b1;
            end
          end else begin
            zcnt_d = '0;
          end
        end
      end
      ST_SYNCED: begin
        if (dv) begin
          timer_d = TMR_LOAD;
          if (rx_byte != 8'h00) begin
            partial_d = {16'h0000, rx_byte};
            idx_d     = 2'd1;
            state_d   = ST_RECORD;
          end
        end
      end
      ST_RECORD: begin
        if (dv) begin
          timer_d = TMR_LOAD;
          if (idx_q == 2'd3) begin
            push      = 1'b1;
            idx_d     = 2'd0;
            partial_d = '0;
            if (rec_word == EOF_WORD) begin
              push_eof = 1'b1;
              state_d  = ST_HUNT;
              zcnt_d   = '0;
            end
          end else begin
            partial_d = {partial_q[15:0], rx_byte};
            idx_d     = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    if (timed_out) begin
      state_d    = ST_HUNT;
      zcnt_d     = '0;
      idx_d      = '0;
      partial_d  = '0;
      sync_err_d = 1'b1;
    end
  end

  // Record FIFO, first-word-fall-through; storage is not reset.
  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             valid, pop, full, wr_en;
  logic [32:0]      head;

  assign valid = (count != '0);
  assign full  = (count == CNT_FULL);
  assign pop   = valid && bus.i_Point_Ready;
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= {push_eof, rec_word};
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !wr_en) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.o_Point_Valid = valid;
  assign bus.o_Point_Data  = valid ? head[31:0] : 32'h0;
  assign bus.o_Point_Eof   = valid ? head[32] : 1'b0;
  assign bus.o_Overflow    = overflow_q;
  assign bus.o_Sync_Err    = sync_err_q;

endmodule

// File: tb/tb_uart_vector_parser.sv
// Directed bench for uart_vector_parser: preamble hunt, record framing,
// timeout, FIFO overflow/simultaneous push-pop and mid-record reset.
module tb_uart_vector_parser;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  uart_vector_parser_if bus ();

  uart_vector_parser #(
    .SYNC_LEN    (4),
    .TIMEOUT_CLKS(4096),
    .DEPTH       (16)
  ) dut (
    .i_Clock(clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_Rx_DV = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Point_Ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One byte followed by one idle cycle.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_Rx_DV = 1'b1;
    bus.i_Rx_Byte = b;
    @(negedge clk);
    bus.i_Rx_DV = 1'b0;
  endtask

  task automatic preamble();
    for (int i = 0; i < 4; i++) send_byte(8'h00);
  endtask

  // Four back-to-back bytes MSB-first; optionally pop during the last byte.
  task automatic send_word(input logic [31:0] w, input bit pop_last);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      bus.i_Rx_DV = 1'b1;
      bus.i_Rx_Byte = w[i*8 +: 8];
      if (i == 0 && pop_last) bus.i_Point_Ready = 1'b1;
    end
    @(negedge clk);
    bus.i_Rx_DV = 1'b0;
    bus.i_Point_Ready = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d, input logic e);
    check({tag, "_valid"}, 64'(bus.o_Point_Valid), 64'd1);
    check({tag, "_data"}, 64'(bus.o_Point_Data), 64'(d));
    check({tag, "_eof"}, 64'(bus.o_Point_Eof), 64'(e));
    bus.i_Point_Ready = 1'b1;
    @(negedge clk);
    bus.i_Point_Ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] w;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.i_Rx_DV = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Point_Ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid", 64'(bus.o_Point_Valid), 64'd0);
    check("rst_data", 64'(bus.o_Point_Data), 64'd0);
    check("rst_eof", 64'(bus.o_Point_Eof), 64'd0);
    check("rst_ovf", 64'(bus.o_Overflow), 64'd0);
    check("rst_err", 64'(bus.o_Sync_Err), 64'd0);
    rst_n = 1'b1;

    // 1: 8 zeros, one point, then eof marker
    for (int i = 0; i < 8; i++) send_byte(8'h00);
    check("t1_idle", 64'(bus.o_Point_Valid), 64'd0);
    send_word(32'h0102_0304, 1'b0);
    check("t1_latency", 64'(bus.o_Point_Valid), 64'd1);
    send_word(32'h0101_0101, 1'b0);
    pop_expect("t1_pt", 32'h0102_0304, 1'b0);
    pop_expect("t1_eof", 32'h0101_0101, 1'b1);
    check("t1_empty", 64'(bus.o_Point_Valid), 64'd0);
    send_word(32'h0102_0304, 1'b0);
    check("t1_hunt", 64'(bus.o_Point_Valid), 64'd0);

    // 2: broken 3-zero run rejected, zeros inside a record kept
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    send_word(32'h0A00_0B00, 1'b0);
    check("t2_reject", 64'(bus.o_Point_Valid), 64'd0);
    preamble();
    send_word(32'h0A00_0B00, 1'b0);
    pop_expect("t2_pt", 32'h0A00_0B00, 1'b0);
    check("t2_empty", 64'(bus.o_Point_Valid), 64'd0);

    // 3: timeout after a partial record
    do_reset();
    preamble();
    send_byte(8'h0A);
    send_byte(8'h0B);
    n = 0;
    while (!bus.o_Sync_Err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t3_err_seen", 64'(bus.o_Sync_Err), 64'd1);
    check("t3_err_time", 64'(n >= 4090 && n <= 4100), 64'd1);
    check("t3_no_push", 64'(bus.o_Point_Valid), 64'd0);
    @(negedge clk);
    check("t3_err_pulse", 64'(bus.o_Sync_Err), 64'd0);
    send_word(32'h0A0B_0C0D, 1'b0);
    check("t3_ignored", 64'(bus.o_Point_Valid), 64'd0);
    check("t3_err_quiet", 64'(bus.o_Sync_Err), 64'd0);

    // 4: 17 records into a 16-deep FIFO
    do_reset();
    preamble();
    for (int i = 0; i < 17; i++) begin
      w = {8'(i + 1), 8'h22, 8'h33, 8'h44};
      send_word(w, 1'b0);
      if (i == 15) check("t4_ovf_at16", 64'(bus.o_Overflow), 64'd0);
    end
    check("t4_ovf", 64'(bus.o_Overflow), 64'd1);
    for (int i = 0; i < 16; i++) begin
      w = {8'(i + 1), 8'h22, 8'h33, 8'h44};
      pop_expect($sformatf("t4_drain%0d", i), w, 1'b0);
    end
    check("t4_empty", 64'(bus.o_Point_Valid), 64'd0);
    check("t4_ovf_sticky", 64'(bus.o_Overflow), 64'd1);

    // 5: push and pop on the same cycle while full
    do_reset();
    preamble();
    for (int i = 0; i < 16; i++) begin
      w = {8'(i + 1), 8'h22, 8'h33, 8'h44};
      send_word(w, 1'b0);
    end
    send_word({8'd17, 8'h22, 8'h33, 8'h44}, 1'b1);
    check("t5_no_ovf", 64'(bus.o_Overflow), 64'd0);
    for (int i = 1; i < 17; i++) begin
      w = {8'(i + 1), 8'h22, 8'h33, 8'h44};
      pop_expect($sformatf("t5_drain%0d", i), w, 1'b0);
    end
    check("t5_empty", 64'(bus.o_Point_Valid), 64'd0);

    // 6: reset mid-record with entries queued
    do_reset();
    preamble();
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    send_word(32'h3333_3333, 1'b0);
    send_byte(8'h44);
    send_byte(8'h55);
    check("t6_queued", 64'(bus.o_Point_Valid), 64'd1);
    do_reset();
    check("t6_valid", 64'(bus.o_Point_Valid), 64'd0);
    check("t6_data", 64'(bus.o_Point_Data), 64'd0);
    check("t6_ovf", 64'(bus.o_Overflow), 64'd0);
    send_word(32'h0102_0304, 1'b0);
    check("t6_hunt", 64'(bus.o_Point_Valid), 64'd0);
    preamble();
    send_word(32'hAABB_CCDD, 1'b0);
    send_word(32'h0101_0101, 1'b0);
    pop_expect("t6_pt", 32'hAABB_CCDD, 1'b0);
    pop_expect("t6_eof", 32'h0101_0101, 1'b1);
    check("t6_empty", 64'(bus.o_Point_Valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
